block_check_sched: RTL
======================

# block_check_sched

Front-end scheduler that shares one keyword-balance checker between two character-stream requesters. It grants one requester a whole message and buffers it locally, so source stalls never reach the checker. It then clears the checker and replays the message to it contiguously, one byte per clock. It samples the checker's verdict and returns it to the owning requester as a one-cycle response. It sits between the text sources and the checker instance, and is the only driver of the checker's reset and input.

## Interface
- DEPTH, 16: message buffer capacity in bytes (power of two, ≥2); pointer/count width is log2(DEPTH)+1.
- TERM, 8'h0A: message terminator byte; consumed, never stored or replayed.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- req0_valid  in  1  requester 0 byte valid.
- req0_data  in  8  requester 0 byte.
- req0_ready  out  1  byte accepted when valid & ready.
- req1_valid / req1_data / req1_ready: same as above, for requester 1.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  1  requester the response belongs to.
- rsp_ok  out  1  1 = message balanced (checker result was 1).
- rsp_ovf  out  1  1 = message exceeded DEPTH bytes; rsp_ok forced 0.
- busy  out  1  high in every state except IDLE.
- chk_reset  out  1  checker synchronous reset.
- chk_in  out  8  checker byte input; consumed every clock.
- chk_result  in  1  checker registered verdict; valid the cycle after a byte is driven.

## Operation
- States: IDLE, COLLECT, CLEAR, PLAY, DELIM, SAMPLE, RESP.
- IDLE: both readys 0.
  - Only one valid: grant it.
  - Both valid: grant the one not granted last. The last-grant register resets to 1, so req0 wins the first tie.
  - Any grant: latch gnt, clear count and ovf, go to COLLECT.
- COLLECT: ready=1 only for gnt.
  - Handshake with data==TERM: go to CLEAR.
  - Handshake with other data: if count<DEPTH, write buf[count] and count++. Otherwise drop the byte and set ovf.
  - No handshake: hold.
- CLEAR: chk_reset=1 for exactly one cycle; rd=0.
  - ovf set: go to RESP.
  - count==0: go to DELIM.
  - Otherwise: go to PLAY.
- PLAY: chk_in=buf[rd], rd++. After driving buf[count-1], go to DELIM.
- DELIM: chk_in=8'h20 for one cycle. The trailing space closes the final word. Go to SAMPLE.
- SAMPLE: capture rsp_ok<=chk_result. Go to RESP.
- RESP: rsp_valid=1, rsp_id=gnt, rsp_ovf=ovf, rsp_ok=ok & ~ovf. Update last-grant to gnt. Go to IDLE.
- chk_in is 8'h20 in every state other than PLAY.
- rsp_id, rsp_ok and rsp_ovf hold their values until the next RESP.
- No readys are asserted outside COLLECT. A requester's bytes of one message are never interleaved with the other requester's.

## Timing
- Reset values:
  - State IDLE, req0_ready=0, req1_ready=0.
  - rsp_valid=0, rsp_id=0, rsp_ok=0, rsp_ovf=0, busy=0.
  - chk_in=8'h20, count=0, ovf=0, last-grant=1.
  - chk_reset=1 while reset is high, since chk_reset = reset | (state==CLEAR).
- Grant latency: a valid seen in IDLE at cycle G gives ready=1 at G+1. No byte is accepted in cycle G.
- Terminator handshake at cycle T, count=N, no overflow:
  - CLEAR at T+1.
  - Bytes on chk_in during T+2..T+N+1.
  - Space at T+N+2.
  - Sample at T+N+3.
  - rsp_valid at T+N+4.
- Empty message (N=0): rsp_valid at T+4 with rsp_ok=1.
- Overflow: rsp_valid at T+2 with rsp_ovf=1, rsp_ok=0. Playback is skipped.
- Exactly DEPTH bytes is not an overflow.
- Reset in any state: next cycle is IDLE with reset values and the buffer logically empty. No response is emitted for the aborted message, and the checker is reset with it.
- Back-to-back: after RESP, the next grant decision is made in IDLE at the following cycle.

## Test plan
- req0 sends "begin end" + 8'h0A with no stalls (N=9) -> bytes on chk_in at T+2..T+10, 8'h20 at T+11, rsp_valid at T+13 with rsp_id=0, rsp_ok=1, rsp_ovf=0.
- req1 sends "begin" + 8'h0A with valid toggling every other cycle -> chk_in shows 5 contiguous bytes regardless of the gaps; rsp_valid at T+9 with rsp_id=1, rsp_ok=0.
- Both requesters valid at the first IDLE after reset -> req0 served first; req1 is granted next even though req0 presents a new message; req0 is served third; rsp_id sequence 0,1,0.
- DEPTH=16, req0 sends 20 letters + TERM -> only 16 stored, ovf set; rsp_valid at T+2 with rsp_ovf=1, rsp_ok=0; a following 2-byte message returns rsp_ovf=0.
- reset asserted mid-PLAY -> next cycle busy=0, readys 0, chk_in=8'h20, no rsp_valid; a resubmitted "end" message then returns its verdict normally with the checker freshly cleared.
- Empty message (TERM only) -> single CLEAR cycle, then 8'h20; rsp_valid at T+4 with rsp_ok=1.

Source files
------------

// File: rtl/block_check_sched_if.sv
// block_check_sched_if
//   Requester/response bundle of the keyword-checker scheduler.
//   master : text-source side. Drives reqN_valid/reqN_data and receives
//            reqN_ready and the rsp_* response.
//   slave  : scheduler side.
//   Signals:
//     req0_valid/req0_data/req0_ready : requester 0 byte stream (valid/ready)
//     req1_valid/req1_data/req1_ready : requester 1 byte stream (valid/ready)
//     rsp_valid                       : one-cycle response pulse
//     rsp_id/rsp_ok/rsp_ovf           : owner, verdict, overflow (held)
interface block_check_sched_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       rsp_valid;
    logic       rsp_id;
    logic       rsp_ok;
    logic       rsp_ovf;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_ok, rsp_ovf
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_ok, rsp_ovf
    );
endinterface

// File: rtl/block_check_sched.sv
// block_check_sched
//   Shares one keyword-balance checker between two byte-stream requesters.
//   A granted requester's whole message is buffered locally, then the
//   checker is cleared and the message is replayed to it contiguously,
//   followed by one space that closes the final word. The checker's verdict
//   is returned to the owner as a one-cycle response.
//   Ports:
//     clk        : clock, rising edge
//     reset      : synchronous, active-high
//     bus        : requester streams and response (slave modport)
//     busy       : high whenever the scheduler is not idle
//     chk_reset  : checker synchronous reset (follows reset, plus CLEAR)
//     chk_in     : checker byte input, consumed every clock
//     chk_result : checker registered verdict
module block_check_sched #(
    parameter int         DEPTH = 16,
    parameter logic [7:0] TERM  = 8'h0A
) (
    input  logic                 clk,
    input  logic                 reset,
    block_check_sched_if.slave   bus,
    output logic                 busy,
    output logic                 chk_reset,
    output logic [7:0]           chk_in,
    input  logic                 chk_result
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [7:0]    SPACE   = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_CLEAR,
        S_PLAY,
        S_DELIM,
        S_SAMPLE,
        S_RESP
    } state_t;

    state_t        state;
    logic          gnt;
    logic          last_gnt;
    logic          ovf;
    logic [CW-1:0] count;
    logic [CW-1:0] rd;      // index of the next byte to put on chk_in
    logic [7:0]    mem [DEPTH];

    logic          pick;
    logic          hs;
    logic [7:0]    hs_data;
    logic          wr_en;

    // Tie goes to the requester that was not served last.
    assign pick = bus.req1_valid & (~bus.req0_valid | ~last_gnt);

    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        hs      = bus.req0_valid & bus.req0_ready;
        hs_data = bus.req0_data;
        if (gnt) begin
            hs      = bus.req1_valid & bus.req1_ready;
            hs_data = bus.req1_data;
        end
    end

    assign wr_en = (state == S_COLLECT) && hs && (hs_data != TERM) && (count < DEPTH_C);

    // NOTE: the message buffer has no reset; count alone decides which
    // entries are meaningful, so clearing count empties it logically.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count[AW-1:0]] <= hs_data;
        end
    end

    assign busy      = (state != S_IDLE);
    assign chk_reset = reset | (state == S_CLEAR);

    // NOTE: all state here uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            gnt            <= 1'b0;
            last_gnt       <= 1'b1;
            ovf            <= 1'b0;
            count          <= '0;
            rd             <= '0;
            chk_in         <= SPACE;
            bus.req0_ready <= 1'b0;
            bus.req1_ready <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_ok     <= 1'b0;
            bus.rsp_ovf    <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req0_valid | bus.req1_valid) begin
                        gnt            <= pick;
                        count          <= '0;
                        ovf            <= 1'b0;
                        bus.req0_ready <= ~pick;
                        bus.req1_ready <= pick;
                        state          <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (hs) begin
                        if (hs_data == TERM) begin
                            bus.req0_ready <= 1'b0;
                            bus.req1_ready <= 1'b0;
                            state          <= S_CLEAR;
                        end else if (count < DEPTH_C) begin
                            count <= count + CW'(1);
                        end else begin
                            ovf <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    rd <= '0;
                    if (ovf) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_id    <= gnt;
                        bus.rsp_ok    <= 1'b0;
                        bus.rsp_ovf   <= 1'b1;
                        state         <= S_RESP;
                    end else if (count == '0) begin
                        state <= S_DELIM;
                    end else begin
                        // chk_in is registered, so the first byte is loaded
                        // on the way into PLAY.
                        chk_in <= mem[0];
                        rd     <= CW'(1);
                        state  <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (rd == count) begin
                        chk_in <= SPACE;
                        state  <= S_DELIM;
                    end else begin
                        chk_in <= mem[rd[AW-1:0]];
                        rd     <= rd + CW'(1);
                    end
                end
                S_DELIM: begin
                    state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    // chk_result now reflects the closing space.
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_id    <= gnt;
                    bus.rsp_ok    <= chk_result;
                    bus.rsp_ovf   <= 1'b0;
                    state         <= S_RESP;
                end
                S_RESP: begin
                    last_gnt <= gnt;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
